// File: rtl/thumb_dmem_master.sv
// rtl/thumb_dmem_master.sv - data-memory bus initiator with programmable read/write wait cycles
// Load/store requests become active-low strobe sequences on a shared tristate data bus.
module thumb_dmem_master #(
   parameter int WORD_SIZE  = 32,
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req,
   input  logic                 req_we,
   input  logic [WORD_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 busy,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 rd_valid,
   output logic                 wr_done,
   output logic                 read_data_n,
   output logic                 write_data_n,
   output logic [WORD_SIZE-1:0] data_address,
   inout  wire  [WORD_SIZE-1:0] data
);

   localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_STROBE,
      S_WR_SETUP,
      S_WR_STROBE,
      S_WR_HOLD
   } state_t;

   state_t                r_state, w_state;
   logic [CW-1:0]         r_cnt, w_cnt;
   logic [WORD_SIZE-1:0]  r_addr, w_addr;
   logic [WORD_SIZE-1:0]  r_wdata, w_wdata;
   logic [WORD_SIZE-1:0]  r_rdata, w_rdata;
   logic                  r_oe, w_oe;
   logic                  r_rd_n, w_rd_n;
   logic                  r_wr_n, w_wr_n;
   logic                  r_rd_valid, w_rd_valid;
   logic                  r_wr_done, w_wr_done;
   logic                  r_busy, w_busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_oe       <= 1'b0;
         r_rd_n     <= 1'b1;
         r_wr_n     <= 1'b1;
         r_rd_valid <= 1'b0;
         r_wr_done  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_addr     <= w_addr;
         r_wdata    <= w_wdata;
         r_rdata    <= w_rdata;
         r_oe       <= w_oe;
         r_rd_n     <= w_rd_n;
         r_wr_n     <= w_wr_n;
         r_rd_valid <= w_rd_valid;
         r_wr_done  <= w_wr_done;
         r_busy     <= w_busy;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_addr     = r_addr;
      w_wdata    = r_wdata;
      w_rdata    = r_rdata;
      w_oe       = r_oe;
      w_rd_n     = r_rd_n;
      w_wr_n     = r_wr_n;
      w_busy     = r_busy;
      w_rd_valid = 1'b0;
      w_wr_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_addr  = req_addr;
               w_wdata = req_wdata;
               w_busy  = 1'b1;
               // Stores get a setup cycle with the bus driven before the strobe falls.
               if (req_we) begin
                  w_state = S_WR_SETUP;
                  w_oe    = 1'b1;
               end else begin
                  w_state = S_RD_STROBE;
                  w_rd_n  = 1'b0;
                  w_cnt   = CW'(READ_WAIT - 1);
               end
            end
         end
         S_RD_STROBE: begin
            if (r_cnt != '0) begin
               w_cnt = r_cnt - 1'b1;
            end else begin
               w_rdata    = data;
               w_rd_valid = 1'b1;
               w_rd_n     = 1'b1;
               w_busy     = 1'b0;
               w_state    = S_IDLE;
            end
         end
         S_WR_SETUP: begin
            w_wr_n  = 1'b0;
            w_cnt   = CW'(WRITE_WAIT - 1);
            w_state = S_WR_STROBE;
         end
         S_WR_STROBE: begin
            if (r_cnt != '0) begin
               w_cnt = r_cnt - 1'b1;
            end else begin
               w_wr_n  = 1'b1;
               w_state = S_WR_HOLD;
            end
         end
         S_WR_HOLD: begin
            w_oe      = 1'b0;
            w_wr_done = 1'b1;
            w_busy    = 1'b0;
            w_state   = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
            w_oe    = 1'b0;
            w_rd_n  = 1'b1;
            w_wr_n  = 1'b1;
            w_busy  = 1'b0;
         end
      endcase
   end

   assign busy         = r_busy;
   assign rdata        = r_rdata;
   assign rd_valid     = r_rd_valid;
   assign wr_done      = r_wr_done;
   assign read_data_n  = r_rd_n;
   assign write_data_n = r_wr_n;
   assign data_address = r_addr;
   assign data         = r_oe ? r_wdata : {WORD_SIZE{1'bz}};

endmodule
